// File: rtl/phase_2b_pkg.sv
// Shared constants and reference helpers for the phase_2b bitstream rotator.
package phase_2b_pkg;

  localparam int K_W   = 2;
  localparam int MAX_W = 64;

  // Reference rotate: r[i] = bits[(i+k) mod n] over the low n bits.
  function automatic logic [MAX_W-1:0] rot_right(
    input logic [MAX_W-1:0] bits,
    input int               n,
    input logic [K_W-1:0]   k
  );
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) r[i] = bits[(i + int'(k)) % n];
    end
    return r;
  endfunction

  function automatic logic [6:0] popcount(
    input logic [MAX_W-1:0] bits
  );
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + 7'(bits[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/phase_2b_rot.sv
// Combinational two-stage barrel rotator: right by 1, then right by 2.
module phase_2b_rot
  import phase_2b_pkg::*;
#(
  parameter int BITSTREAM = 8
) (
  input  logic [K_W-1:0]       k,
  input  logic [BITSTREAM-1:0] in_bits,
  output logic [BITSTREAM-1:0] out_bits
);

  logic [BITSTREAM-1:0] s1;

  // Index wrap is resolved at elaboration, so shifts never reach N.
  for (genvar i = 0; i < BITSTREAM; i++) begin : g_rot
    localparam int I1 = (i + 1) % BITSTREAM;
    localparam int I2 = (i + 2) % BITSTREAM;
    assign s1[i]       = k[0] ? in_bits[I1] : in_bits[i];
    assign out_bits[i] = k[1] ? s1[I2] : s1[i];
  end

endmodule

// File: rtl/phase_2b.sv
// Bitstream phase-shift stage: zero-latency rotate plus 1-cycle registered copy.
// Optional popcount checker enabled by defining PHASE_2B_POPCHK_EN.
module phase_2b
  import phase_2b_pkg::*;
#(
  parameter int BITSTREAM = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [K_W-1:0]       k,
  input  logic [BITSTREAM-1:0] in_bits,
  output logic [BITSTREAM-1:0] out_bits,
  output logic [BITSTREAM-1:0] out_bits_q,
  output logic                 out_valid,
  output logic                 popchk_err
);

  logic [BITSTREAM-1:0] rot_bits;

  phase_2b_rot #(
    .BITSTREAM(BITSTREAM)
  ) u_rot (
    .k       (k),
    .in_bits (in_bits),
    .out_bits(rot_bits)
  );

  assign out_bits = rot_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bits_q <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_bits_q <= rot_bits;
    end
  end

`ifdef PHASE_2B_POPCHK_EN
  logic pop_bad;

  assign pop_bad = popcount(MAX_W'(rot_bits)) != popcount(MAX_W'(in_bits));

  // Sticky until reset so a single corrupted sample is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      popchk_err <= 1'b0;
    end else if (in_valid && pop_bad) begin
      popchk_err <= 1'b1;
    end
  end
`else
  assign popchk_err = 1'b0;
`endif

endmodule

// File: tb/tb_phase_2b.sv
// Directed bench for phase_2b (N = 8): rotate vectors, registered path, async reset.
module tb_phase_2b;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] k;
  logic [7:0] in_bits;
  logic [7:0] out_bits;
  logic [7:0] out_bits_q;
  logic       out_valid;
  logic       popchk_err;

  int checks = 0;
  int errors = 0;

  phase_2b #(.BITSTREAM(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .k         (k),
    .in_bits   (in_bits),
    .out_bits  (out_bits),
    .out_bits_q(out_bits_q),
    .out_valid (out_valid),
    .popchk_err(popchk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model: take the low byte of the doubled word shifted right.
  function automatic logic [7:0] model(input logic [7:0] b, input logic [1:0] kk);
    logic [15:0] d;
    d = {b, b} >> kk;
    return d[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] r;
    rst      = 1'b1;
    in_valid = 1'b0;
    k        = 2'd0;
    in_bits  = 8'h00;
    #2;
    check("reset_q",     out_bits_q,        8'h00);
    check("reset_valid", {7'd0, out_valid}, 8'h00);
    check("reset_err",   {7'd0, popchk_err}, 8'h00);

    // Combinational path, independent of clk/rst
    k = 2'd0; in_bits = 8'hA5; #1;
    check("comb_k0_a5", out_bits, 8'hA5);
    k = 2'd1; in_bits = 8'h81; #1;
    check("comb_k1_81", out_bits, 8'hC0);
    k = 2'd2; in_bits = 8'h01; #1;
    check("comb_k2_01", out_bits, 8'h40);
    k = 2'd3; in_bits = 8'h0F; #1;
    check("comb_k3_0f", out_bits, 8'hE1);

    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; k = 2'd1; in_bits = 8'h81;
    @(posedge clk); #1;
    check("reg_q_c0",   out_bits_q,        8'hC0);
    check("reg_valid1", {7'd0, out_valid}, 8'h01);

    @(negedge clk);
    in_valid = 1'b0; k = 2'd0; in_bits = 8'hFF;
    @(posedge clk); #1;
    check("hold_q_c0",  out_bits_q,        8'hC0);
    check("hold_valid", {7'd0, out_valid}, 8'h00);

    @(negedge clk);
    in_valid = 1'b1; k = 2'd3; in_bits = 8'h0F;
    @(posedge clk); #1;
    check("reg_q_e1", out_bits_q, 8'hE1);

    // Async reset between edges, with a valid sample still presented
    @(negedge clk); #1;
    rst = 1'b1; #1;
    check("async_q",     out_bits_q,        8'h00);
    check("async_valid", {7'd0, out_valid}, 8'h00);
    @(posedge clk); #1;
    check("rst_hold_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", {7'd0, out_valid}, 8'h00);
    check("post_rst_q",     out_bits_q,        8'h00);

    // Sweep: k cycles every vector, both paths checked
    for (int q = 0; q <= 100; q++) begin
      @(negedge clk);
      k        = 2'(q % 4);
      in_bits  = 8'($urandom);
      in_valid = 1'b1;
      r        = model(in_bits, k);
      #1;
      check("sweep_comb", out_bits, r);
      @(posedge clk); #1;
      check("sweep_q",     out_bits_q,        r);
      check("sweep_valid", {7'd0, out_valid}, 8'h01);
    end
    check("sweep_err", {7'd0, popchk_err}, 8'h00);

`ifdef PHASE_2B_POPCHK_EN
    for (int q = 0; q < 1000; q++) begin
      @(negedge clk);
      k = 2'($urandom); in_bits = 8'($urandom); in_valid = 1'b1;
    end
    @(posedge clk); #1;
    check("pop_clean", {7'd0, popchk_err}, 8'h00);
    @(negedge clk);
    in_bits = 8'hFF; in_valid = 1'b1;
    force dut.rot_bits = 8'h00;
    @(posedge clk); #1;
    release dut.rot_bits;
    check("pop_set", {7'd0, popchk_err}, 8'h01);
    @(negedge clk);
    in_bits = 8'h3C;
    @(posedge clk); #1;
    check("pop_sticky", {7'd0, popchk_err}, 8'h01);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    check("pop_clear", {7'd0, popchk_err}, 8'h00);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
